// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: reserves register-file writes as instructions leave D and
// ages them through E/M/W. From those reservations it derives the D-stage stall
// and the forwarding selects for D, E and M.
// Optional build macro: HAZARD_STALL_CNT_EN adds a 32-bit count of stall cycles.
module hazard_scoreboard #(
    parameter logic [1:0] TUSE_NONE = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_wr,
    input  logic [4:0]  d_dst,
    input  logic [1:0]  d_wdsel,
    output logic        stall,
    output logic [1:0]  fwd_d_rs,
    output logic [1:0]  fwd_d_rt,
    output logic [1:0]  fwd_e_rs,
    output logic [1:0]  fwd_e_rt,
    output logic [1:0]  fwd_m_rt
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_E    = 2'b01;
    localparam logic [1:0] SRC_M    = 2'b10;
    localparam logic [1:0] SRC_W    = 2'b11;

    // E record
    logic       r_e_wr;
    logic [4:0] r_e_dst;
    logic [1:0] r_e_tnew;
    logic [4:0] r_e_rs;
    logic [4:0] r_e_rt;
    // M record; only rt is consumed downstream (store data)
    logic       r_m_wr;
    logic [4:0] r_m_dst;
    logic [1:0] r_m_tnew;
    logic [4:0] r_m_rt;
    // W record; tnew is always 0 here so it is not stored
    logic       r_w_wr;
    logic [4:0] r_w_dst;

    logic       w_d_wr;
    logic [1:0] w_d_tnew;
    logic [1:0] w_m_tnew_next;
    logic [3:0] w_rs_look;
    logic [3:0] w_rt_look;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall;

    // Youngest-match lookup for a D operand: returns {stage code, tnew}.
    // Stage code SRC_NONE means no stage reserves this register.
    function automatic logic [3:0] d_lookup(input logic [4:0] r);
        logic [3:0] res;
        res = {SRC_NONE, 2'b00};
        if (r != 5'd0) begin
            if (r_e_wr && (r_e_dst == r))
                res = {SRC_E, r_e_tnew};
            else if (r_m_wr && (r_m_dst == r))
                res = {SRC_M, r_m_tnew};
            else if (r_w_wr && (r_w_dst == r))
                res = {SRC_W, 2'b00};
        end
        return res;
    endfunction

    // Writes to r0 are never reserved; jal link data is ready at once, ALU
    // results after E, load data after M.
    assign w_d_wr   = d_wr && (d_dst != 5'd0);
    assign w_d_tnew = (d_wdsel == 2'b10) ? 2'd0 :
                      (d_wdsel == 2'b01) ? 2'd2 : 2'd1;
    assign w_m_tnew_next = (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;

    assign w_rs_look = d_lookup(d_rs);
    assign w_rt_look = d_lookup(d_rt);

    assign w_stall_rs = (d_tuse_rs != TUSE_NONE) && (w_rs_look[3:2] != SRC_NONE) &&
                        (w_rs_look[1:0] > d_tuse_rs);
    assign w_stall_rt = (d_tuse_rt != TUSE_NONE) && (w_rt_look[3:2] != SRC_NONE) &&
                        (w_rt_look[1:0] > d_tuse_rt);
    assign w_stall    = w_stall_rs || w_stall_rt;
    assign stall      = w_stall;

    // D forwarding only from a stage whose result is already available
    assign fwd_d_rs = ((w_rs_look[3:2] != SRC_NONE) && (w_rs_look[1:0] == 2'd0)) ?
                      w_rs_look[3:2] : SRC_NONE;
    assign fwd_d_rt = ((w_rt_look[3:2] != SRC_NONE) && (w_rt_look[1:0] == 2'd0)) ?
                      w_rt_look[3:2] : SRC_NONE;

    // E forwarding: a matching M that is not yet ready shadows W, since W
    // would hold an older (stale) value of the same register.
    always_comb begin
        fwd_e_rs = SRC_NONE;
        if (r_e_rs != 5'd0) begin
            if (r_m_wr && (r_m_dst == r_e_rs))
                fwd_e_rs = (r_m_tnew == 2'd0) ? SRC_M : SRC_NONE;
            else if (r_w_wr && (r_w_dst == r_e_rs))
                fwd_e_rs = SRC_W;
        end
    end

    // Same selection for the E-stage rt operand
    always_comb begin
        fwd_e_rt = SRC_NONE;
        if (r_e_rt != 5'd0) begin
            if (r_m_wr && (r_m_dst == r_e_rt))
                fwd_e_rt = (r_m_tnew == 2'd0) ? SRC_M : SRC_NONE;
            else if (r_w_wr && (r_w_dst == r_e_rt))
                fwd_e_rt = SRC_W;
        end
    end

    assign fwd_m_rt = ((r_m_rt != 5'd0) && r_w_wr && (r_w_dst == r_m_rt)) ? SRC_W : SRC_NONE;

    // Advance the reservation records one stage per cycle; a stall bubbles E
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_wr   <= 1'b0;
            r_e_dst  <= 5'd0;
            r_e_tnew <= 2'd0;
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_m_wr   <= 1'b0;
            r_m_dst  <= 5'd0;
            r_m_tnew <= 2'd0;
            r_m_rt   <= 5'd0;
            r_w_wr   <= 1'b0;
            r_w_dst  <= 5'd0;
        end else begin
            r_w_wr   <= r_m_wr;
            r_w_dst  <= r_m_dst;
            r_m_wr   <= r_e_wr;
            r_m_dst  <= r_e_dst;
            r_m_tnew <= w_m_tnew_next;
            r_m_rt   <= r_e_rt;
            if (w_stall) begin
                r_e_wr   <= 1'b0;
                r_e_dst  <= 5'd0;
                r_e_tnew <= 2'd0;
                r_e_rs   <= 5'd0;
                r_e_rt   <= 5'd0;
            end else begin
                r_e_wr   <= w_d_wr;
                r_e_dst  <= d_dst;
                r_e_tnew <= w_d_tnew;
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count stalled cycles; wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= 32'd0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
